ysyx_25040111_mem_arbiter: RTL and testbench
============================================

YSYX_25040111_MEM_ARBITER -- requirements
Module: ysyx_25040111_mem_arbiter

Interface
REQ-001 SHALL have: clock  in  1  system clock; all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: ic_rstart  in  1  icache refill request, single-cycle pulse.
REQ-004 SHALL have: ic_addr  in  32  icache refill address, sampled on ic_rstart.
REQ-005 SHALL have: ic_rlen  in  8  icache beat count, sampled on ic_rstart; 0 means 1.
REQ-006 SHALL have: ic_rok  out  1  icache beat-valid pulse, one per beat.
REQ-007 SHALL have: ic_rdata  out  32  icache beat data, valid while ic_rok=1.
REQ-008 SHALL have: ls_start  in  1  LSU request pulse.
REQ-009 SHALL have: ls_wen  in  1  LSU write enable (1=write), sampled on ls_start.
REQ-010 SHALL have: ls_addr / ls_wdata  in  32 / 32  LSU address and write data, sampled on ls_start.
REQ-011 SHALL have: ls_wmask  in  4  LSU byte strobes, sampled on ls_start.
REQ-012 SHALL have: ls_ok  out  1  LSU completion pulse.
REQ-013 SHALL have: ls_rdata  out  32  LSU load data, valid while ls_ok=1.
REQ-014 SHALL have: m_start  out  1  downstream transaction-start pulse.
REQ-015 SHALL have: m_addr / m_wdata  out  32 / 32  downstream address and write data.
REQ-016 SHALL have: m_wen / m_wmask / m_len  out  1 / 4 / 8  downstream write flag, strobes, beat count.
REQ-017 SHALL have: m_ok / m_rdata  in  1 / 32  downstream beat-done pulse and read data.

Function
REQ-018 SHALL hold one pending flag plus captured fields per requester; a start pulse sets the flag and captures fields at that clock edge.
REQ-019 SHALL ignore a start pulse from a requester whose pending flag is set or which is in service; fields are not overwritten.
REQ-020 SHALL implement FSM states IDLE, ISSUE, BUSY.
REQ-021 IDLE: any pending flag set -> select winner, load m_* from its captured fields, go to ISSUE; else stay.
REQ-022 ISSUE: m_start=1 for exactly this one cycle; winner's pending flag cleared; go to BUSY.
REQ-023 BUSY: m_addr/m_wen/m_wdata/m_wmask/m_len held stable; each m_ok increments an 8-bit beat counter.
REQ-024 Beat target = captured len, with 0 treated as 1; LSU transactions always use m_len=1.
REQ-025 On the m_ok that reaches the beat target: counter cleared, state -> IDLE.
REQ-026 m_ok in IDLE or ISSUE SHALL be ignored.
REQ-027 ic_rok/ic_rdata SHALL be registered copies of m_ok/m_rdata during icache service: one-cycle latency, one pulse per beat.
REQ-028 ls_ok/ls_rdata SHALL be registered copies of the final m_ok/m_rdata during LSU service; ls_rdata is don't-care for writes.
REQ-029 A requester's own start pulse in the same cycle as its completion SHALL be accepted (service has ended).
REQ-030 Minimum gap between back-to-back transactions: return to IDLE, then ISSUE on the next cycle.
REQ-031 m_wen=0 and m_wmask=0 SHALL hold for icache transactions.

Reset
REQ-032 Reset SHALL clear: state->IDLE, pending flags, beat counter, round-robin pointer; m_start, ic_rok, ls_ok, m_wen = 0; m_wmask = 0; m_len = 0.
REQ-033 m_addr, m_wdata, ic_rdata and ls_rdata SHALL reset to 0.
REQ-034 Reset mid-BUSY SHALL abandon the transaction with no ok pulse to any requester; later stray m_ok is ignored per REQ-026.

Configuration
REQ-035 With YSYX_25040111_ARB_RR_EN defined: round-robin arbitration; the pointer flips to the other requester after each ISSUE; ties go to the pointed requester.
REQ-036 Without YSYX_25040111_ARB_RR_EN: fixed priority, LSU over icache.
REQ-037 Either build: a single pending requester SHALL be granted regardless of pointer or priority.

Verification
REQ-038 ic_rstart, ic_addr=0x8000_0040, ic_rlen=4; m_ok on 4 cycles with data 0x11,0x22,0x33,0x44 -> single m_start with m_len=4; ic_rok four pulses, each one cycle after m_ok, with matching data; then IDLE.
REQ-039 ls_start with ls_wen=1, ls_addr=0x8000_1000, ls_wdata=0xDEAD_BEEF, ls_wmask=0xF -> m_start with m_wen=1, m_len=1 and matching fields; one m_ok -> one ls_ok pulse.
REQ-040 ic_rstart and ls_start in the same cycle, without RR -> LSU issued first, icache second. With RR after reset (pointer=icache) -> icache first, then LSU.
REQ-041 Second ic_rstart arriving during icache BUSY -> ignored; exactly one icache transaction occurs.
REQ-042 Reset asserted after 2 of 4 beats, then m_ok pulses -> no ic_rok, FSM in IDLE, m_start=0, no pending flags.
REQ-043 ic_rlen=0 -> m_len=0 driven; the transaction ends after one m_ok with one ic_rok.

Source files
------------

// File: rtl/ysyx_25040111_mem_arbiter.sv
// rtl/ysyx_25040111_mem_arbiter.sv - two-requester arbiter (icache refill, LSU) onto one downstream memory port
//
// Purpose:
//   Captures one outstanding request per requester into a pending slot.
//   Grants one slot at a time to the downstream port through an
//   IDLE -> ISSUE -> BUSY sequence, and relays the beat completions back
//   to the owning requester.
//
// Build option:
//   YSYX_25040111_ARB_RR_EN  defined   : round-robin between requesters; the
//                                        pointer moves to the other requester
//                                        after each ISSUE, and ties go to the
//                                        pointed requester (icache after reset).
//                            undefined : fixed priority, LSU over icache.
//   In both builds a lone pending requester is always granted.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ic_rstart/ic_addr/ic_rlen  icache refill request pulse, address, beat count (0 = 1 beat)
//   ic_rok/ic_rdata         icache per-beat valid pulse and data (one cycle after m_ok)
//   ls_start/ls_wen/ls_addr/ls_wdata/ls_wmask  LSU request pulse and fields
//   ls_ok/ls_rdata          LSU completion pulse and load data (one cycle after final m_ok)
//   m_start                 downstream start pulse, high only in ISSUE
//   m_addr/m_wdata/m_wen/m_wmask/m_len  downstream command, stable from ISSUE through BUSY
//   m_ok/m_rdata            downstream beat-done pulse and read data (ignored outside BUSY)

module ysyx_25040111_mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ic_rstart,
  input  logic [31:0] ic_addr,
  input  logic [7:0]  ic_rlen,
  output logic        ic_rok,
  output logic [31:0] ic_rdata,
  input  logic        ls_start,
  input  logic        ls_wen,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wmask,
  output logic        ls_ok,
  output logic [31:0] ls_rdata,
  output logic        m_start,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wen,
  output logic [3:0]  m_wmask,
  output logic [7:0]  m_len,
  input  logic        m_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t      state;

  // Pending slots: flag plus the fields captured on the accepted start pulse.
  logic        ic_pend;
  logic [31:0] ic_addr_q;
  logic [7:0]  ic_len_q;
  logic        ls_pend;
  logic        ls_wen_q;
  logic [31:0] ls_addr_q;
  logic [31:0] ls_wdata_q;
  logic [3:0]  ls_wmask_q;

  // Owner of the transaction currently in ISSUE/BUSY (1 = LSU).
  logic        svc_ls;
  logic [7:0]  beat_cnt;
  // Number of m_ok beats that ends the transaction; icache len 0 still means one beat.
  logic [7:0]  beat_target;

`ifdef YSYX_25040111_ARB_RR_EN
  // 0 = icache is favoured on a tie, 1 = LSU is favoured.
  logic        rr_ptr;
`endif

  logic        last_beat;
  logic        ic_in_svc;
  logic        ls_in_svc;
  logic        ic_accept;
  logic        ls_accept;
  logic        grant_ls;

  assign last_beat = (state == BUSY) && m_ok && ((beat_cnt + 8'd1) == beat_target);

  // The completion cycle no longer counts as in service, so a requester may
  // launch its next request in the same cycle its current one finishes.
  assign ic_in_svc = (state != IDLE) && !svc_ls && !last_beat;
  assign ls_in_svc = (state != IDLE) &&  svc_ls && !last_beat;

  // A start pulse is dropped while the requester already has a pending slot or
  // is being served; the captured fields are then left untouched.
  assign ic_accept = ic_rstart && !ic_pend && !ic_in_svc;
  assign ls_accept = ls_start  && !ls_pend && !ls_in_svc;

`ifdef YSYX_25040111_ARB_RR_EN
  assign grant_ls = ls_pend && (!ic_pend || rr_ptr);
`else
  assign grant_ls = ls_pend;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ic_pend     <= 1'b0;
      ic_addr_q   <= 32'd0;
      ic_len_q    <= 8'd0;
      ls_pend     <= 1'b0;
      ls_wen_q    <= 1'b0;
      ls_addr_q   <= 32'd0;
      ls_wdata_q  <= 32'd0;
      ls_wmask_q  <= 4'd0;
      svc_ls      <= 1'b0;
      beat_cnt    <= 8'd0;
      beat_target <= 8'd0;
`ifdef YSYX_25040111_ARB_RR_EN
      rr_ptr      <= 1'b0;
`endif
      m_start     <= 1'b0;
      m_addr      <= 32'd0;
      m_wdata     <= 32'd0;
      m_wen       <= 1'b0;
      m_wmask     <= 4'd0;
      m_len       <= 8'd0;
      ic_rok      <= 1'b0;
      ic_rdata    <= 32'd0;
      ls_ok       <= 1'b0;
      ls_rdata    <= 32'd0;
    end else begin
      // Pulse outputs default low; the cases below raise them for one cycle.
      m_start <= 1'b0;
      ic_rok  <= 1'b0;
      ls_ok   <= 1'b0;

      if (ic_accept) begin
        ic_pend   <= 1'b1;
        ic_addr_q <= ic_addr;
        ic_len_q  <= ic_rlen;
      end

      if (ls_accept) begin
        ls_pend    <= 1'b1;
        ls_wen_q   <= ls_wen;
        ls_addr_q  <= ls_addr;
        ls_wdata_q <= ls_wdata;
        ls_wmask_q <= ls_wmask;
      end

      case (state)
        IDLE: begin
          if (ic_pend || ls_pend) begin
            svc_ls   <= grant_ls;
            beat_cnt <= 8'd0;
            m_start  <= 1'b1;
            state    <= ISSUE;
            if (grant_ls) begin
              m_addr      <= ls_addr_q;
              m_wdata     <= ls_wdata_q;
              m_wen       <= ls_wen_q;
              m_wmask     <= ls_wmask_q;
              m_len       <= 8'd1;
              beat_target <= 8'd1;
            end else begin
              m_addr      <= ic_addr_q;
              m_wdata     <= 32'd0;
              m_wen       <= 1'b0;
              m_wmask     <= 4'd0;
              // m_len carries the raw request (0 stays 0); only the local
              // beat target folds 0 into a single beat.
              m_len       <= ic_len_q;
              beat_target <= (ic_len_q == 8'd0) ? 8'd1 : ic_len_q;
            end
          end
        end

        ISSUE: begin
          // The winner's slot is freed here; the winner cannot be re-accepted
          // this cycle because it is in service, so nothing races the clear.
          if (svc_ls) begin
            ls_pend <= 1'b0;
          end else begin
            ic_pend <= 1'b0;
          end
`ifdef YSYX_25040111_ARB_RR_EN
          rr_ptr <= !svc_ls;
`endif
          state <= BUSY;
        end

        BUSY: begin
          if (m_ok) begin
            if (svc_ls) begin
              ls_ok    <= last_beat;
              ls_rdata <= m_rdata;
            end else begin
              ic_rok   <= 1'b1;
              ic_rdata <= m_rdata;
            end
            if (last_beat) begin
              beat_cnt <= 8'd0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// tb/tb_ysyx_25040111_mem_arbiter.sv - self-checking bench for ysyx_25040111_mem_arbiter
`timescale 1ns/1ps

module tb_ysyx_25040111_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ic_rstart = 1'b0;
  logic [31:0] ic_addr = 32'd0;
  logic [7:0]  ic_rlen = 8'd0;
  logic        ic_rok;
  logic [31:0] ic_rdata;
  logic        ls_start = 1'b0;
  logic        ls_wen = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic [3:0]  ls_wmask = 4'd0;
  logic        ls_ok;
  logic [31:0] ls_rdata;
  logic        m_start;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wen;
  logic [3:0]  m_wmask;
  logic [7:0]  m_len;
  logic        m_ok = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  always #5 clock = ~clock;

  ysyx_25040111_mem_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .ic_rstart (ic_rstart),
    .ic_addr   (ic_addr),
    .ic_rlen   (ic_rlen),
    .ic_rok    (ic_rok),
    .ic_rdata  (ic_rdata),
    .ls_start  (ls_start),
    .ls_wen    (ls_wen),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wmask  (ls_wmask),
    .ls_ok     (ls_ok),
    .ls_rdata  (ls_rdata),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wen     (m_wen),
    .m_wmask   (m_wmask),
    .m_len     (m_len),
    .m_ok      (m_ok),
    .m_rdata   (m_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Pulse counters sampled on the falling edge.
  int n_mstart = 0;
  int n_icrok  = 0;
  int n_lsok   = 0;

  always @(negedge clock) begin
    if (m_start === 1'b1) n_mstart++;
    if (ic_rok === 1'b1)  n_icrok++;
    if (ls_ok === 1'b1)   n_lsok++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5 ms, required to finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    ic_rstart = 1'b0;
    ls_start  = 1'b0;
    m_ok      = 1'b0;
    m_rdata   = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_mstart(input string name, output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (m_start === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s: m_start stayed 0 for 20 cycles, required 1", name);
    end
  endtask

  task automatic serve(input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      tick();
      m_ok    = 1'b1;
      m_rdata = base + 32'(b);
    end
    tick();
    m_ok = 1'b0;
  endtask

  function automatic logic [31:0] bdata(input int i, input int b);
    return 32'(i << 16) | 32'((b + 1) * 32'h11);
  endfunction

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    logic        is_ls;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [7:0]  len;
    logic [7:0]  exp_len;
    logic        exp_wen;
    logic [3:0]  exp_wmask;
    int          exp_beats;
  } vec_t;

  vec_t vecs[7];

  task automatic chk_ok(input int i, input vec_t v, input int b);
    if (v.is_ls) begin
      check($sformatf("vec%0d ls_ok", i), ls_ok, 1);
      if (!v.wen) check($sformatf("vec%0d ls_rdata", i), ls_rdata, bdata(i, b));
    end else begin
      check($sformatf("vec%0d ic_rok beat%0d", i, b), ic_rok, 1);
      check($sformatf("vec%0d ic_rdata beat%0d", i, b), ic_rdata, bdata(i, b));
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    int n0s, n0i, n0l;
    v   = vecs[i];
    n0s = n_mstart;
    n0i = n_icrok;
    n0l = n_lsok;
    tick();
    if (v.is_ls) begin
      ls_start = 1'b1; ls_wen = v.wen; ls_addr = v.addr; ls_wdata = v.wdata; ls_wmask = v.wmask;
    end else begin
      ic_rstart = 1'b1; ic_addr = v.addr; ic_rlen = v.len;
    end
    tick();
    ic_rstart = 1'b0;
    ls_start  = 1'b0;
    ic_addr   = 32'hFFFF_FFFF;
    ic_rlen   = 8'hFF;
    ls_addr   = 32'hFFFF_FFFF;
    ls_wdata  = 32'd0;
    ls_wmask  = 4'd0;
    ls_wen    = ~v.wen;
    check($sformatf("vec%0d m_start before issue", i), m_start, 0);
    tick();
    check($sformatf("vec%0d m_start", i), m_start, 1);
    check($sformatf("vec%0d m_addr", i), m_addr, v.addr);
    check($sformatf("vec%0d m_len", i), m_len, v.exp_len);
    check($sformatf("vec%0d m_wen", i), m_wen, v.exp_wen);
    check($sformatf("vec%0d m_wmask", i), m_wmask, v.exp_wmask);
    if (v.is_ls && v.wen) check($sformatf("vec%0d m_wdata", i), m_wdata, v.wdata);
    for (int b = 0; b < v.exp_beats; b++) begin
      tick();
      if (b > 0) chk_ok(i, v, b - 1);
      m_ok    = 1'b1;
      m_rdata = bdata(i, b);
    end
    tick();
    m_ok = 1'b0;
    chk_ok(i, v, v.exp_beats - 1);
    repeat (4) tick();
    check($sformatf("vec%0d m_start count", i), n_mstart - n0s, 1);
    check($sformatf("vec%0d ic_rok count", i), n_icrok - n0i, v.is_ls ? 0 : v.exp_beats);
    check($sformatf("vec%0d ls_ok count", i), n_lsok - n0l, v.is_ls ? 1 : 0);
  endtask

  // ---------------- randomized run with transaction-level model ----------------
  typedef struct {
    bit          is_ls;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [7:0]  len;
    int          pulse_cyc;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } okexp_t;

  req_t   ic_q[$];
  req_t   ls_q[$];
  okexp_t ic_exp[$];
  okexp_t ls_exp[$];

  task automatic run_random(input int total, input int gen_until);
    bit   ic_out, ls_out, act, act_start, prev_idle, started_now;
    bit   ic_e, ls_e, exp_start, win_ls, e_ic, e_ls;
    bit   rr_m;
    int   beats_left, n_txn;
    req_t cur, r;
    ic_out = 0; ls_out = 0; act = 0; prev_idle = 1; beats_left = 0; n_txn = 0; rr_m = 0;
    cur = '{default: '0};
    for (int it = 0; it < total; it++) begin
      tick();
      act_start = act;

      e_ic = (ic_exp.size() > 0) && (ic_exp[0].cyc == cyc);
      if (ic_rok === 1'b1 || e_ic) begin
        check("rnd ic_rok", ic_rok, e_ic);
        if (e_ic) begin
          if (ic_rok === 1'b1) check("rnd ic_rdata", ic_rdata, ic_exp[0].data);
          void'(ic_exp.pop_front());
        end
      end
      e_ls = (ls_exp.size() > 0) && (ls_exp[0].cyc == cyc);
      if (ls_ok === 1'b1 || e_ls) begin
        check("rnd ls_ok", ls_ok, e_ls);
        if (e_ls) begin
          if (ls_ok === 1'b1 && ls_exp[0].chk) check("rnd ls_rdata", ls_rdata, ls_exp[0].data);
          void'(ls_exp.pop_front());
        end
      end

      // A request is visible to the grant decision two cycles after its pulse.
      ic_e      = (ic_q.size() > 0) && (ic_q[0].pulse_cyc <= cyc - 2);
      ls_e      = (ls_q.size() > 0) && (ls_q[0].pulse_cyc <= cyc - 2);
      exp_start = prev_idle && (ic_e || ls_e);
      if (m_start === 1'b1 || exp_start) check("rnd m_start", m_start, exp_start);
      started_now = 0;
      if (exp_start) begin
        if (ic_e && ls_e) begin
`ifdef YSYX_25040111_ARB_RR_EN
          win_ls = rr_m;
`else
          win_ls = 1'b1;
`endif
        end else begin
          win_ls = ls_e;
        end
        rr_m = !win_ls;
        cur  = win_ls ? ls_q.pop_front() : ic_q.pop_front();
        check("rnd issue m_addr", m_addr, cur.addr);
        check("rnd issue m_len", m_len, cur.is_ls ? 8'd1 : cur.len);
        check("rnd issue m_wen", m_wen, cur.is_ls ? cur.wen : 1'b0);
        check("rnd issue m_wmask", m_wmask, cur.is_ls ? cur.wmask : 4'd0);
        if (cur.is_ls && cur.wen) check("rnd issue m_wdata", m_wdata, cur.wdata);
        act         = 1;
        started_now = 1;
        beats_left  = cur.is_ls ? 1 : ((cur.len == 8'd0) ? 1 : int'(cur.len));
      end
      if (act_start) begin
        check("rnd busy m_addr hold", m_addr, cur.addr);
        check("rnd busy m_start low", m_start, 0);
      end
      prev_idle = !act_start && !exp_start;

      // Downstream responder.
      m_ok    = 1'b0;
      m_rdata = $urandom;
      if (act && !started_now) begin
        if ($urandom_range(0, 2) != 0) begin
          m_ok = 1'b1;
          if (cur.is_ls) ls_exp.push_back('{cyc + 1, m_rdata, !cur.wen});
          else           ic_exp.push_back('{cyc + 1, m_rdata, 1'b1});
          beats_left--;
          if (beats_left == 0) begin
            act = 0;
            n_txn++;
            if (cur.is_ls) ls_out = 0; else ic_out = 0;
          end
        end
      end else if ($urandom_range(0, 5) == 0) begin
        m_ok = 1'b1;
      end

      // Requesters: fields change every cycle, only the pulse cycle matters.
      ic_rstart = 1'b0;
      ls_start  = 1'b0;
      ic_addr   = $urandom;
      ic_rlen   = 8'($urandom_range(0, 6));
      ls_wen    = 1'($urandom_range(0, 1));
      ls_addr   = $urandom;
      ls_wdata  = $urandom;
      ls_wmask  = 4'($urandom_range(0, 15));
      if (it < gen_until) begin
        if (!ic_out && $urandom_range(0, 2) == 0) begin
          ic_rstart = 1'b1;
          r = '{0, 0, ic_addr, 32'd0, 4'd0, ic_rlen, cyc};
          ic_q.push_back(r);
          ic_out = 1;
        end else if (ic_out && $urandom_range(0, 9) == 0) begin
          ic_rstart = 1'b1;
        end
        if (!ls_out && $urandom_range(0, 2) == 0) begin
          ls_start = 1'b1;
          r = '{1, ls_wen, ls_addr, ls_wdata, ls_wmask, 8'd1, cyc};
          ls_q.push_back(r);
          ls_out = 1;
        end else if (ls_out && $urandom_range(0, 9) == 0) begin
          ls_start = 1'b1;
        end
      end
    end
    idle_inputs();
    check("rnd ic requests drained", ic_q.size(), 0);
    check("rnd ls requests drained", ls_q.size(), 0);
    check("rnd ic_rok expectations drained", ic_exp.size(), 0);
    check("rnd ls_ok expectations drained", ls_exp.size(), 0);
    check("rnd transaction finished", act, 0);
    check("rnd enough transactions", (n_txn >= 100) ? 1 : 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          got;
    int          n0s, n0i;
    logic [31:0] first_a, second_a;

    vecs[0] = '{1'b0, 1'b0, 32'h8000_0040, 32'h0,         4'h0, 8'd4,   8'd4,   1'b0, 4'h0, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 8'd0,   8'd1,   1'b1, 4'hF, 1};
    vecs[2] = '{1'b0, 1'b0, 32'h8000_0100, 32'h0,         4'h0, 8'd0,   8'd0,   1'b0, 4'h0, 1};
    vecs[3] = '{1'b1, 1'b0, 32'h8000_2004, 32'h0,         4'h0, 8'd0,   8'd1,   1'b0, 4'h0, 1};
    vecs[4] = '{1'b0, 1'b0, 32'h8000_0200, 32'h0,         4'h0, 8'd1,   8'd1,   1'b0, 4'h0, 1};
    vecs[5] = '{1'b1, 1'b1, 32'h8000_3000, 32'h1234_5678, 4'h3, 8'd0,   8'd1,   1'b1, 4'h3, 1};
    vecs[6] = '{1'b0, 1'b0, 32'h8000_0300, 32'h0,         4'h0, 8'd255, 8'd255, 1'b0, 4'h0, 255};

    do_reset();
    check("reset m_start", m_start, 0);
    check("reset ic_rok", ic_rok, 0);
    check("reset ls_ok", ls_ok, 0);
    check("reset m_wen/m_wmask/m_len", {19'd0, m_wen, m_wmask, m_len}, 0);
    check("reset m_addr", m_addr, 0);
    check("reset m_wdata", m_wdata, 0);
    check("reset ic_rdata", ic_rdata, 0);
    check("reset ls_rdata", ls_rdata, 0);

    for (int i = 0; i < 7; i++) apply_vec(i);

    // Simultaneous requests right after reset.
    do_reset();
    tick();
    ic_rstart = 1'b1; ic_addr = 32'h8000_0A00; ic_rlen = 8'd1;
    ls_start  = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0B00; ls_wmask = 4'd0;
    tick();
    ic_rstart = 1'b0; ls_start = 1'b0;
`ifdef YSYX_25040111_ARB_RR_EN
    first_a = 32'h8000_0A00; second_a = 32'h8000_0B00;
`else
    first_a = 32'h8000_0B00; second_a = 32'h8000_0A00;
`endif
    wait_mstart("tie first grant", got);
    if (got) check("tie first m_addr", m_addr, first_a);
    serve(1, 32'hA000_0000);
    wait_mstart("tie second grant", got);
    if (got) check("tie second m_addr", m_addr, second_a);
    serve(1, 32'hB000_0000);
    repeat (3) tick();

    // Second icache start while busy is ignored.
    do_reset();
    n0s = n_mstart; n0i = n_icrok;
    tick();
    ic_rstart = 1'b1; ic_addr = 32'h8000_0C00; ic_rlen = 8'd4;
    tick();
    ic_rstart = 1'b0;
    wait_mstart("dup first grant", got);
    tick();
    m_ok = 1'b1; m_rdata = 32'h0C00_0000;
    ic_rstart = 1'b1; ic_addr = 32'h8000_0D00; ic_rlen = 8'd2;
    tick();
    ic_rstart = 1'b0; m_rdata = 32'h0C00_0001;
    tick(); m_rdata = 32'h0C00_0002;
    tick(); m_rdata = 32'h0C00_0003;
    tick(); m_ok = 1'b0;
    repeat (10) tick();
    check("dup m_start count", n_mstart - n0s, 1);
    check("dup ic_rok count", n_icrok - n0i, 4);

    // Reset in the middle of a burst, with an LSU request pending.
    do_reset();
    n0s = n_mstart; n0i = n_icrok;
    tick();
    ic_rstart = 1'b1; ic_addr = 32'h8000_0E00; ic_rlen = 8'd4;
    tick();
    ic_rstart = 1'b0;
    wait_mstart("midrst grant", got);
    tick();
    m_ok = 1'b1; m_rdata = 32'h0E00_0000;
    ls_start = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0F00;
    tick();
    ls_start = 1'b0; m_rdata = 32'h0E00_0001;
    tick();
    m_ok = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst m_start after reset", m_start, 0);
    check("midrst ic_rok after reset", ic_rok, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      m_ok = 1'b1; m_rdata = 32'hBAD0_0000 + 32'(k);
    end
    tick();
    m_ok = 1'b0;
    repeat (6) tick();
    check("midrst ic_rok count", n_icrok - n0i, 2);
    check("midrst m_start count", n_mstart - n0s, 1);
    tick();
    ic_rstart = 1'b1; ic_addr = 32'h8000_1100; ic_rlen = 8'd1;
    tick();
    ic_rstart = 1'b0;
    tick();
    check("midrst next m_start", m_start, 1);
    check("midrst next m_addr", m_addr, 32'h8000_1100);
    serve(1, 32'h1100_0000);
    repeat (3) tick();

    // Restart pulse in the same cycle as completion is accepted.
    do_reset();
    tick();
    ic_rstart = 1'b1; ic_addr = 32'h8000_1200; ic_rlen = 8'd1;
    tick();
    ic_rstart = 1'b0;
    wait_mstart("restart first grant", got);
    tick();
    m_ok = 1'b1; m_rdata = 32'h5555_0001;
    ic_rstart = 1'b1; ic_addr = 32'h8000_1300; ic_rlen = 8'd2;
    tick();
    m_ok = 1'b0; ic_rstart = 1'b0;
    check("restart ic_rok", ic_rok, 1);
    check("restart idle m_start", m_start, 0);
    tick();
    check("restart m_start", m_start, 1);
    check("restart m_addr", m_addr, 32'h8000_1300);
    check("restart m_len", m_len, 8'd2);
    serve(2, 32'h1300_0000);
    repeat (3) tick();

    do_reset();
    run_random(3000, 2700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
